// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          PC_INC    = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; used for in-flight PC tags and for
// fetched entries waiting for decode.
module fetch_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic [31:0]
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  T                           din,
    input  logic                       pop,
    input  logic                       flush,
    output T                           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    T              mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign count   = cnt;
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited word requests to imem, in-order
// responses tagged with their PC and buffered for decode; redirect flushes.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    input  logic            out_ready
);

    import fetch_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    logic            started;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] last_pc;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   tag_count;
    logic [CW-1:0]   out_count;
    logic [XLEN-1:0] tag_pc;
    logic            tag_empty, tag_full;
    logic            out_empty, out_full;
    logic            req_fire, rsp_fire, keep_rsp;
    fetch_entry_t    push_entry, head;

    // Every in-flight fetch is either a stale one awaiting discard (drop)
    // or a live one with a tag, so outstanding needs no register of its own.
    assign outstanding = drop + tag_count;

    assign imem_req_valid = started && !redirect_valid
                            && ((32'(outstanding) + 32'(out_count)) < DEPTH);
    assign imem_req_addr  = pc;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_fire = imem_rsp_valid && (drop != '0 || !tag_empty);
    assign keep_rsp = rsp_fire && !redirect_valid && (drop == '0);

    assign push_entry = '{pc: tag_pc, instr: imem_rsp_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started <= 1'b0;
            pc      <= RESET_PC;
            drop    <= '0;
            last_pc <= RESET_PC;
        end else begin
            started <= 1'b1;
            if (!out_empty) last_pc <= head.pc;
            if (redirect_valid) begin
                pc   <= {redirect_pc[XLEN-1:2], 2'b00};
                drop <= rsp_fire ? outstanding - CW'(1) : outstanding;
            end else begin
                if (req_fire) pc <= pc + XLEN'(PC_INC);
                if (rsp_fire && drop != '0) drop <= drop - CW'(1);
            end
        end
    end

    fetch_fifo #(.DEPTH(DEPTH), .T(logic [XLEN-1:0])) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (req_fire && !tag_full),
        .din   (pc),
        .pop   (keep_rsp),
        .flush (redirect_valid),
        .dout  (tag_pc),
        .count (tag_count),
        .empty (tag_empty),
        .full  (tag_full)
    );

    fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_out_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (keep_rsp && !out_full),
        .din   (push_entry),
        .pop   (out_ready),
        .flush (redirect_valid),
        .dout  (head),
        .count (out_count),
        .empty (out_empty),
        .full  (out_full)
    );

    assign out_valid = !out_empty;
    assign out_instr = out_empty ? NOP_INSTR : head.instr;
    assign out_pc    = out_empty ? last_pc : head.pc;

`ifndef SYNTHESIS
    a_rsp_needs_fetch: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> (outstanding != '0));
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit: in-order memory model plus a stream
// model of the PCs decode should see (sequential from reset or last redirect).
module tb_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready = 1'b0;

    fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] req_log[$];
    int unsigned cyc = 0;
    int          n_chk = 0, n_fail = 0;
    int          n_req = 0, n_pop = 0;
    int          p_ready = 100, p_out = 100, p_rsp = 100, p_redir = 0;
    int          lat_lo = 1, lat_hi = 1;
    bit          redir_req = 0, redir_on_rsp = 0;
    logic [31:0] redir_tgt = '0;
    logic [31:0] exp_req, exp_out, last_seen;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h00C0_FFEE;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One cycle: drive inputs at negedge, sample 1 time unit later, update models.
    task automatic step();
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (mq.size() != 0 && mq[0].due <= cyc && $urandom_range(99) < p_rsp) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
        end
        imem_req_ready = ($urandom_range(99) < p_ready);
        out_ready      = ($urandom_range(99) < p_out);
        redirect_valid = 1'b0;
        if (redir_req || (redir_on_rsp && imem_rsp_valid)) begin
            redirect_valid = 1'b1;
            redirect_pc    = redir_tgt;
            redir_req      = 0;
            redir_on_rsp   = 0;
        end else if ($urandom_range(999) < p_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = $urandom();
        end
        #1;
        if (imem_req_valid) chk("req_addr", imem_req_addr, exp_req);
        if (redirect_valid) chk("req_in_redirect", 32'(imem_req_valid), 0);
        if (out_valid) begin
            chk("out_pc", out_pc, exp_out);
            chk("out_instr", out_instr, mem_word(exp_out));
            last_seen = out_pc;
        end else begin
            chk("empty_nop", out_instr, NOP);
            chk("empty_pc_hold", out_pc, last_seen);
        end
        if (imem_rsp_valid) void'(mq.pop_front());
        if (imem_req_valid && imem_req_ready) begin
            mq.push_back('{addr: imem_req_addr, due: cyc + $urandom_range(lat_lo, lat_hi)});
            req_log.push_back(imem_req_addr);
            exp_req += 32'd4;
            n_req++;
        end
        if (out_valid && out_ready && !redirect_valid) begin
            exp_out += 32'd4;
            n_pop++;
        end
        if (redirect_valid) begin
            exp_req = {redirect_pc[31:2], 2'b00};
            exp_out = {redirect_pc[31:2], 2'b00};
        end
        chk("credit_bound", 32'(mq.size() <= DEPTH), 1);
        cyc++;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        redir_req      = 0;
        redir_on_rsp   = 0;
        mq.delete();
        req_log.delete();
        exp_req   = RESET_PC;
        exp_out   = RESET_PC;
        last_seen = RESET_PC;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 0);
        chk("rst_req_addr", imem_req_addr, RESET_PC);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_instr", out_instr, NOP);
        chk("rst_out_pc", out_pc, RESET_PC);
        rst_n          = 1'b1;
        imem_req_ready = 1'b1;
        #1;
        chk("start_gap", 32'(imem_req_valid), 0);
    endtask

    task automatic wait_out_valid(input string tag, input logic [31:0] pc_exp);
        int k = 0;
        while (!out_valid && k < 30) begin step(); k++; end
        chk({tag, "_seen"}, 32'(out_valid), 1);
        chk(tag, out_pc, pc_exp);
    endtask

    task automatic wait_reqs(input int n);
        int k = 0;
        while (req_log.size() < n && k < 40) begin step(); k++; end
        chk("req_timeout", 32'(req_log.size() >= n), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // 1: free-running fetch from reset
        do_reset();
        p_ready = 100; p_out = 100; lat_lo = 1; lat_hi = 1;
        wait_out_valid("first_pc", 32'h0);
        n_pop = 0;
        repeat (20) step();
        chk("throughput", 32'(n_pop >= 8), 1);

        // 2: decode stall fills credits, then drains in order
        do_reset();
        p_out = 0; n_req = 0;
        repeat (10) step();
        chk("stall_reqs", n_req, 2);
        chk("stall_req_valid", 32'(imem_req_valid), 0);
        p_out = 100;
        wait_out_valid("drain_first", 32'h0);
        req_log.delete();
        wait_reqs(1);
        chk("resume_addr", req_log[0], 32'h8);

        // 3: redirect with two fetches in flight
        lat_lo = 3; lat_hi = 3;
        for (int k = 0; k < 20 && mq.size() != 2; k++) step();
        chk("inflight_two", mq.size(), 2);
        redir_tgt = 32'h100; redir_req = 1;
        step();
        step();
        chk("flush_empty", 32'(out_valid), 0);
        lat_lo = 1; lat_hi = 1;
        wait_out_valid("redir_first", 32'h100);
        step();
        wait_out_valid("redir_second", 32'h104);

        // 4: unaligned redirect coinciding with a response
        repeat (3) step();
        redir_tgt = 32'h203; redir_on_rsp = 1;
        for (int k = 0; k < 10 && redir_on_rsp; k++) step();
        chk("redir_rsp_hit", 32'(redir_on_rsp), 0);
        req_log.delete();
        wait_reqs(1);
        chk("redir_align", req_log[0], 32'h200);

        // 5: PC wrap
        redir_tgt = 32'hFFFF_FFF8; redir_req = 1;
        step();
        req_log.delete();
        wait_reqs(3);
        chk("wrap0", req_log[0], 32'hFFFF_FFF8);
        chk("wrap1", req_log[1], 32'hFFFF_FFFC);
        chk("wrap2", req_log[2], 32'h0000_0000);

        // 6: asynchronous reset with a full buffer
        p_out = 0;
        repeat (8) step();
        chk("full_valid", 32'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(out_valid), 0);
        chk("async_out_instr", out_instr, NOP);
        chk("async_req_valid", 32'(imem_req_valid), 0);
        do_reset();
        p_out = 100;
        wait_reqs(1);
        chk("post_rst_pc", req_log[0], RESET_PC);

        // Random traffic with random redirects
        for (int seg = 0; seg < 6; seg++) begin
            if (seg == 3) do_reset();
            p_ready = $urandom_range(100, 30);
            p_out   = $urandom_range(100, 20);
            p_rsp   = $urandom_range(100, 50);
            lat_lo  = 1;
            lat_hi  = $urandom_range(4, 1);
            p_redir = 30;
            repeat (400) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
